// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit paths.
// Contents:
//   ST_*        - FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   PAR_EVEN/ODD- parity type selector values for PAR_TYP
//   PRESCALE_*  - legal oversampling ratios
//   expectedParity - parity bit a frame must carry for its data
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  // dataXor is the XOR reduction of the data bits; odd parity inverts it
  function automatic logic expectedParity(input logic dataXor, input logic parTyp);
    return dataXor ^ (parTyp == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-timing and oversampling engine for the UART receiver.
// Ports:
//   clk, ARST     - system clock, asynchronous active-high reset
//   rxSync_i      - synchronized serial line
//   startFrame_i  - start edge seen this cycle (this cycle is edge 0)
//   active_i      - a frame is in progress (FSM not idle)
//   prescale_i    - oversampling ratio, latched at startFrame_i
//   sampledBit_o  - majority vote of the three mid-bit samples
//   bitTick_o     - last oversampling cycle of the current bit
module uart_rx_sampler (
  input  logic       clk,
  input  logic       ARST,
  input  logic       rxSync_i,
  input  logic       startFrame_i,
  input  logic       active_i,
  input  logic [5:0] prescale_i,
  output logic       sampledBit_o,
  output logic       bitTick_o
);

  logic [5:0] prescale_q;
  logic [5:0] edgeCnt_q, edgeCnt_d;
  logic [2:0] samples_q;
  logic [5:0] halfBit;
  logic [5:0] lastEdge;

  assign halfBit  = {1'b0, prescale_q[5:1]};
  assign lastEdge = prescale_q - 6'd1;

  // The start-detect cycle is edge 0 of the start bit, so the counter
  // resumes at 1; it wraps at P-1 so each bit restarts cleanly at 0.
  always_comb begin
    edgeCnt_d = edgeCnt_q;
    if (startFrame_i) begin
      edgeCnt_d = 6'd1;
    end else if (active_i) begin
      edgeCnt_d = (edgeCnt_q == lastEdge) ? 6'd0 : edgeCnt_q + 6'd1;
    end
  end

  // Prescale is captured once per frame so a mid-frame change cannot
  // stretch or shrink bits; samples are taken around the bit centre.
  always_ff @(posedge clk or posedge ARST) begin
    if (ARST) begin
      prescale_q <= 6'd0;
      edgeCnt_q  <= 6'd0;
      samples_q  <= 3'b000;
    end else begin
      edgeCnt_q <= edgeCnt_d;
      if (startFrame_i) begin
        prescale_q <= prescale_i;
      end
      if (active_i) begin
        if (edgeCnt_q == halfBit - 6'd1) samples_q[0] <= rxSync_i;
        if (edgeCnt_q == halfBit)        samples_q[1] <= rxSync_i;
        if (edgeCnt_q == halfBit + 6'd1) samples_q[2] <= rxSync_i;
      end
    end
  end

  assign sampledBit_o = (samples_q[0] & samples_q[1]) |
                        (samples_q[0] & samples_q[2]) |
                        (samples_q[1] & samples_q[2]);
  assign bitTick_o    = active_i && (edgeCnt_q == lastEdge);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detection, LSB-first deserialization, optional
// parity check and stop-bit check, with one-cycle result strobes.
// Ports:
//   clk, ARST   - system clock, asynchronous active-high reset
//   RX_IN       - raw serial line (idles high, asynchronous)
//   Prescale    - oversampling ratio (8, 16 or 32)
//   PAR_EN      - frame carries a parity bit
//   PAR_TYP     - 0 even, 1 odd parity
//   P_DATA      - last good received word
//   DATA_VALID  - pulse when P_DATA updates
//   PAR_ERR     - pulse on parity mismatch
//   STP_ERR     - pulse when the stop bit reads 0
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  ARST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic                  rxMeta_q, rxSync_q;
  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      bitCnt_q, bitCnt_d;
  logic [DATA_WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic                  parFail_q, parFail_d;
  logic [DATA_WIDTH-1:0] pData_q, pData_d;
  logic                  dataValid_q, dataValid_d;
  logic                  parErr_q, parErr_d;
  logic                  stpErr_q, stpErr_d;
  logic                  startFrame;
  logic                  sampledBit;
  logic                  bitTick;

  // Two-flop synchronizer; resets to the idle-high line level so no
  // false start is seen as reset releases.
  always_ff @(posedge clk or posedge ARST) begin
    if (ARST) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= RX_IN;
      rxSync_q <= rxMeta_q;
    end
  end

  assign startFrame = (state_q == ST_IDLE) && !rxSync_q;

  uart_rx_sampler uSampler (
    .clk          (clk),
    .ARST         (ARST),
    .rxSync_i     (rxSync_q),
    .startFrame_i (startFrame),
    .active_i     (state_q != ST_IDLE),
    .prescale_i   (Prescale),
    .sampledBit_o (sampledBit),
    .bitTick_o    (bitTick)
  );

  // Frame FSM. All decisions happen on bitTick; strobes default low so
  // they only ever last the single cycle after the stop decision.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shiftReg_d  = shiftReg_q;
    parFail_d   = parFail_q;
    pData_d     = pData_q;
    dataValid_d = 1'b0;
    parErr_d    = 1'b0;
    stpErr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxSync_q) begin
          state_d   = ST_START;
          parFail_d = 1'b0;
        end
      end
      ST_START: begin
        if (bitTick) begin
          if (sampledBit) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_DATA;
            bitCnt_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (bitTick) begin
          shiftReg_d = {sampledBit, shiftReg_q[DATA_WIDTH-1:1]};
          if (bitCnt_q == LAST_BIT) begin
            bitCnt_d = '0;
            state_d  = PAR_EN ? ST_PARITY : ST_STOP;
          end else begin
            bitCnt_d = bitCnt_q + CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bitTick) begin
          if (sampledBit != expectedParity(^shiftReg_q, PAR_TYP)) begin
            parFail_d = 1'b1;
          end
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bitTick) begin
          state_d  = ST_IDLE;
          stpErr_d = ~sampledBit;
          parErr_d = parFail_q;
          if (sampledBit && !parFail_q) begin
            dataValid_d = 1'b1;
            pData_d     = shiftReg_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge ARST) begin
    if (ARST) begin
      state_q     <= ST_IDLE;
      bitCnt_q    <= '0;
      shiftReg_q  <= '0;
      parFail_q   <= 1'b0;
      pData_q     <= '0;
      dataValid_q <= 1'b0;
      parErr_q    <= 1'b0;
      stpErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shiftReg_q  <= shiftReg_d;
      parFail_q   <= parFail_d;
      pData_q     <= pData_d;
      dataValid_q <= dataValid_d;
      parErr_q    <= parErr_d;
      stpErr_q    <= stpErr_d;
    end
  end

  assign P_DATA     = pData_q;
  assign DATA_VALID = dataValid_q;
  assign PAR_ERR    = parErr_q;
  assign STP_ERR    = stpErr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random frames,
// compared against a frame-level model of expected result events.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       ARST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;

  typedef struct packed {
    logic [31:0] cyc;
    logic        dv;
    logic        pe;
    logic        se;
    logic [7:0]  data;
  } frameEvent_t;

  frameEvent_t observedQ[$];
  frameEvent_t expectedQ[$];

  int unsigned cycle = 0;
  int          testsRun = 0;
  int          failCount = 0;
  logic [7:0]  lastGood = 8'h00;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .ARST       (ARST),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
  );

  // Free-running clock and a cycle counter used to time-stamp results
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Record every cycle with any result strobe high, away from the edge
  always @(negedge clk) begin
    if (DATA_VALID || PAR_ERR || STP_ERR) begin
      observedQ.push_back('{cyc: cycle, dv: DATA_VALID, pe: PAR_ERR,
                            se: STP_ERR, data: P_DATA});
    end
  end

  task automatic chk(input string tag, input logic [31:0] observed,
                     input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Keeps the invariant that the main sequence sits 1 time unit past a rising edge
  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame and records what the receiver should report for it:
  // the result appears 2 sync cycles + frame bits * P after the start edge.
  task automatic applyStimulus(input logic [7:0] data, input logic [5:0] p,
                               input logic parEn, input logic parTyp,
                               input logic badParity, input logic stopBit);
    logic        bits[$];
    logic        parBit;
    frameEvent_t expEv;
    Prescale = p;
    PAR_EN   = parEn;
    PAR_TYP  = parTyp;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (parEn) begin
      parBit = ((($countones(data) + int'(parTyp)) % 2) == 1);
      if (badParity) parBit = ~parBit;
      bits.push_back(parBit);
    end
    bits.push_back(stopBit);
    expEv.cyc = cycle + 2 + bits.size() * int'(p);
    expEv.pe  = parEn && badParity;
    expEv.se  = !stopBit;
    expEv.dv  = !expEv.pe && !expEv.se;
    if (expEv.dv) lastGood = data;
    expEv.data = lastGood;
    expectedQ.push_back(expEv);
    foreach (bits[i]) begin
      RX_IN = bits[i];
      waitCycles(int'(p));
    end
    RX_IN = 1'b1;
  endtask

  // Compares recorded result events against the model, then clears both
  task automatic checkOutput(input string tag);
    frameEvent_t o, e;
    chk({tag, "-count"}, observedQ.size(), expectedQ.size());
    while (observedQ.size() > 0 && expectedQ.size() > 0) begin
      o = observedQ.pop_front();
      e = expectedQ.pop_front();
      chk({tag, "-cycle"}, o.cyc, e.cyc);
      chk({tag, "-valid"}, {31'd0, o.dv}, {31'd0, e.dv});
      chk({tag, "-parerr"}, {31'd0, o.pe}, {31'd0, e.pe});
      chk({tag, "-stperr"}, {31'd0, o.se}, {31'd0, e.se});
      chk({tag, "-data"}, {24'd0, o.data}, {24'd0, e.data});
    end
    observedQ.delete();
    expectedQ.delete();
  endtask

  // Directed plan followed by random frames
  initial begin
    logic [7:0] partial;
    logic [5:0] rp;
    ARST     = 1'b0;
    RX_IN    = 1'b1;
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    #1 ARST = 1'b1;
    waitCycles(3);
    chk("reset-pdata", {24'd0, P_DATA}, 32'd0);
    chk("reset-valid", {31'd0, DATA_VALID}, 32'd0);
    chk("reset-parerr", {31'd0, PAR_ERR}, 32'd0);
    chk("reset-stperr", {31'd0, STP_ERR}, 32'd0);
    ARST = 1'b0;
    waitCycles(4);

    applyStimulus(8'hA5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(6);
    checkOutput("a5-p8");

    applyStimulus(8'h37, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1);
    waitCycles(6);
    checkOutput("37-even-ok");
    applyStimulus(8'h37, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1);
    waitCycles(6);
    checkOutput("37-even-bad");

    applyStimulus(8'h3C, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    waitCycles(6);
    checkOutput("3c-stop0");
    applyStimulus(8'h81, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(6);
    checkOutput("81-after-err");

    Prescale = 6'd16;
    RX_IN = 1'b0;
    waitCycles(3);
    RX_IN = 1'b1;
    waitCycles(40);
    checkOutput("glitch");
    applyStimulus(8'h5A, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(6);
    checkOutput("5a-after-glitch");

    applyStimulus(8'h00, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'hFF, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(6);
    if (observedQ.size() >= 2) begin
      chk("b2b-gap", observedQ[1].cyc - observedQ[0].cyc, 32'd320);
    end
    checkOutput("b2b-p32");

    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    partial  = 8'h96;
    RX_IN    = 1'b0;
    waitCycles(8);
    for (int i = 0; i < 4; i++) begin
      RX_IN = partial[i];
      waitCycles(8);
    end
    ARST = 1'b1;
    lastGood = 8'h00;
    #1;
    chk("midreset-pdata", {24'd0, P_DATA}, 32'd0);
    chk("midreset-valid", {31'd0, DATA_VALID}, 32'd0);
    chk("midreset-parerr", {31'd0, PAR_ERR}, 32'd0);
    chk("midreset-stperr", {31'd0, STP_ERR}, 32'd0);
    RX_IN = 1'b1;
    waitCycles(3);
    ARST = 1'b0;
    waitCycles(4);
    applyStimulus(8'h69, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(6);
    checkOutput("69-after-reset");

    for (int n = 0; n < 10; n++) begin
      case ($urandom_range(2, 0))
        0:       rp = 6'd8;
        1:       rp = 6'd16;
        default: rp = 6'd32;
      endcase
      applyStimulus(8'($urandom), rp, 1'($urandom), 1'($urandom),
                    ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) != 0));
      waitCycles(6 + $urandom_range(5, 0));
      checkOutput($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver. It is the receive-side counterpart of the TX path (TX FSM, serializer, output mux).
- Oversamples RX_IN at Prescale clocks per bit and majority-votes each bit.
- Deserializes DATA_WIDTH bits LSB-first, then checks optional parity and the stop bit.
- Presents the received word with a one-cycle DATA_VALID strobe.
- Sits between the pad-side serial line and the system-side consumer (FIFO or register file).

Parameters:
DATA_WIDTH, 8, number of data bits per frame.

Ports:
clk  input  1  system clock; all logic on rising edge.
ARST  input  1  asynchronous active-high reset.
RX_IN  input  1  serial line; idles high; asynchronous to clk.
Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
PAR_EN  input  1  1 = frame carries a parity bit after the data bits.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
P_DATA  output  DATA_WIDTH  last good received word.
DATA_VALID  output  1  one-cycle pulse when P_DATA is updated.
PAR_ERR  output  1  one-cycle pulse: parity mismatch on the frame just ended.
STP_ERR  output  1  one-cycle pulse: stop bit sampled as 0.

Behaviour:
- Reset: ARST=1 forces the following immediately, mid-frame included; the partial frame is discarded.
  - P_DATA=0; DATA_VALID, PAR_ERR, STP_ERR = 0.
  - State = IDLE; internal counters = 0.
  - Synchronizer flops = 1.
- Input sync: RX_IN passes a 2-flop synchronizer (rx_s). All behaviour below refers to rx_s.
- Per-bit timing: edge_cnt counts 0..P-1; one bit = P cycles.
  - P is Prescale, latched on start detection and held for the whole frame. Prescale changes mid-frame have no effect.
- Sampling: rx_s is sampled at edge_cnt = P/2-1, P/2 and P/2+1.
  - sampled_bit = majority of the 3 samples, valid from edge P/2+2.
  - Bit decisions are taken at edge_cnt = P-1.
- IDLE:
  - If rx_s=0, that cycle is edge 0 of the start bit: next state START, edge_cnt <= 1.
  - All outputs low (strobes are pulses only).
- START: at edge P-1:
  - sampled_bit=1 is a glitch: return to IDLE with no outputs.
  - sampled_bit=0: go to DATA; edge_cnt and bit_cnt cleared.
- DATA: at each edge P-1, shift sampled_bit into the shift register (LSB first), bit_cnt++.
  - After DATA_WIDTH bits: go to PARITY if PAR_EN=1, else STOP.
- PARITY: at edge P-1, the expected bit is XOR of the data bits, inverted if PAR_TYP=1.
  - A mismatch sets internal par_fail. Then go to STOP.
- STOP: at edge P-1, go to IDLE and drive one combined frame-end cycle next:
  - STP_ERR = ~sampled_bit.
  - PAR_ERR = par_fail.
  - If neither error: DATA_VALID=1 and P_DATA <= shift register.
  - On any error, P_DATA holds its old value and DATA_VALID stays 0.
  - par_fail is cleared on entry to START.
- Back-to-back frames: the stop bit ends at edge P-1. A start bit beginning the very next cycle is detected from IDLE with no lost edges.
- Frame length: 10 bit-times, or 11 with parity.
  - DATA_VALID asserts 2 sync cycles + frame_len*P cycles after the line's falling start edge.
- PAR_EN and PAR_TYP are sampled at the PARITY decision; they must be held stable during the frame.

Decomposition:
- Package uart_pkg:
  - State encoding (IDLE, START, DATA, PARITY, STOP), shared with the TX FSM.
  - Parity type constants EVEN=0, ODD=1.
  - Legal prescale constants 8/16/32.
- Sub-module uart_rx_sampler:
  - Owns edge_cnt, the three sample flops and the majority vote.
  - Outputs sampled_bit and bit_tick (edge_cnt = P-1).
- The top level holds the FSM, bit counter, shift register, parity/stop checks and output registers.

Test Plan:
- Prescale=8, PAR_EN=0, send 0xA5 -> exactly one DATA_VALID pulse, P_DATA=0xA5, PAR_ERR=STP_ERR=0, pulse 2+80 cycles after the start edge.
- Prescale=16, PAR_EN=1, PAR_TYP=0, send 0x37 with parity bit 1 -> DATA_VALID, P_DATA=0x37.
  - Repeat with parity bit 0 -> PAR_ERR pulse, no DATA_VALID, P_DATA stays 0x37.
- Prescale=8, send 0x3C with stop bit 0 -> STP_ERR pulse, no DATA_VALID.
  - Next correct frame 0x81 -> DATA_VALID, P_DATA=0x81.
- Prescale=16, RX_IN low for 3 cycles then high -> FSM returns to IDLE, no pulses. A following 0x5A frame is received correctly.
- Prescale=32, back-to-back frames 0x00 then 0xFF with zero idle gap -> two DATA_VALID pulses exactly 320 cycles apart, correct data.
- Assert ARST mid-DATA of a 0x96 frame, release, send 0x69 -> all outputs 0 during reset, only 0x69 reported.
